// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Imported by the loader FSM and its byte packer.
package imem_program_loader_pkg;

   localparam int          IMEM_WORDS = 1024;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_BYTE,
      S_WRITE,
      S_CSUM,
      S_VERIFY,
      S_DONE,
      S_ERROR
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_LEN    = 2'd1,
      ERR_CSUM   = 2'd2,
      ERR_VERIFY = 2'd3
   } err_t;

   function automatic logic [7:0] xor_bytes(input logic [31:0] w);
      return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
   endfunction

endpackage

// File: rtl/imem_program_loader_byte_word_packer.sv
// Packs stream bytes into little-endian words and keeps a running XOR
// of every byte shifted in since the last clear.
module byte_word_packer
   import imem_program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_shift,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic [7:0]  o_acc,
   output logic        o_word_ready
);

   logic [1:0]  r_lane;
   logic [31:0] r_word;
   logic [7:0]  r_acc;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_lane <= 2'd0;
         r_word <= 32'd0;
         r_acc  <= 8'd0;
      end else if (i_shift) begin
         r_word[8*r_lane +: 8] <= i_byte;
         r_acc  <= r_acc ^ i_byte;
         r_lane <= r_lane + 2'd1;
      end
   end

   // High on the transfer that completes a word; lane wraps to 0 with it.
   assign o_word_ready = i_shift && (r_lane == 2'd3);
   assign o_word       = r_word;
   assign o_acc        = r_acc;

endmodule

// File: rtl/imem_program_loader.sv
// Loads a framed byte stream into instruction memory via its debug port,
// checks the frame checksum and verifies the image by readback.
module imem_program_loader
   import imem_program_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = IMEM_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic        o_rx_ready,
   output logic        o_dbg_en,
   output logic        o_dbg_write_en,
   output logic [31:0] o_dbg_addr,
   output logic [31:0] o_dbg_wdata,
   input  logic [31:0] i_dbg_rdata,
   output logic        o_cpu_hold,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [1:0]  o_err_code,
   output logic [10:0] o_words_loaded
);

   if ((BASE_ADDR[1:0] != 2'b00) || (MAX_WORDS < 1) ||
       (longint'(BASE_ADDR) + 4 * longint'(MAX_WORDS - 1) >
        4 * longint'(IMEM_WORDS - 1))) begin : g_bad_cfg
      $error("imem_program_loader: image exceeds memory");
   end

   state_t      r_state;
   err_t        r_err;
   logic [15:0] r_len;
   logic [10:0] r_idx;
   logic [10:0] r_words;
   logic [7:0]  r_csum;
   logic [7:0]  r_racc;
   logic        r_busy;
   logic        r_done;
   logic        r_error;

   logic        w_xfer;
   logic        w_shift;
   logic        w_clear;
   logic [31:0] w_word;
   logic [7:0]  w_acc;
   logic        w_word_ready;
   logic [15:0] w_len;
   logic [10:0] w_idx_nx;
   logic [7:0]  w_rb;
   logic [31:0] w_addr;

   assign w_xfer   = i_rx_valid && o_rx_ready;
   assign w_shift  = (r_state == S_BYTE) && w_xfer;
   assign w_clear  = (r_state == S_IDLE) && i_start;
   assign w_len    = {i_rx_data, r_len[7:0]};
   assign w_idx_nx = r_idx + 11'd1;
   assign w_rb     = r_racc ^ xor_bytes(i_dbg_rdata);
   assign w_addr   = BASE_ADDR + {19'd0, r_idx, 2'b00};

   byte_word_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .i_clear      (w_clear),
      .i_shift      (w_shift),
      .i_byte       (i_rx_data),
      .o_word       (w_word),
      .o_acc        (w_acc),
      .o_word_ready (w_word_ready)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_err   <= ERR_NONE;
         r_len   <= 16'd0;
         r_idx   <= 11'd0;
         r_words <= 11'd0;
         r_csum  <= 8'd0;
         r_racc  <= 8'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_LEN_LO;
                  r_busy  <= 1'b1;
                  r_err   <= ERR_NONE;
                  r_words <= 11'd0;
                  r_idx   <= 11'd0;
               end
            end
            S_LEN_LO: begin
               if (w_xfer) begin
                  r_len[7:0] <= i_rx_data;
                  r_state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (w_xfer) begin
                  r_len[15:8] <= i_rx_data;
                  if (w_len == 16'd0 || w_len > 16'(MAX_WORDS)) begin
                     r_state <= S_ERROR;
                     r_err   <= ERR_LEN;
                     r_error <= 1'b1;
                  end else begin
                     r_state <= S_BYTE;
                  end
               end
            end
            S_BYTE: begin
               if (w_word_ready) r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_idx   <= w_idx_nx;
               r_words <= r_words + 11'd1;
               if ({5'd0, w_idx_nx} < r_len) r_state <= S_BYTE;
               else                          r_state <= S_CSUM;
            end
            S_CSUM: begin
               if (w_xfer) begin
                  r_csum <= i_rx_data;
                  if (i_rx_data != w_acc) begin
                     r_state <= S_ERROR;
                     r_err   <= ERR_CSUM;
                     r_error <= 1'b1;
                  end else begin
                     r_state <= S_VERIFY;
                     r_idx   <= 11'd0;
                     r_racc  <= 8'd0;
                  end
               end
            end
            S_VERIFY: begin
               r_racc <= w_rb;
               r_idx  <= w_idx_nx;
               // Last word: the readback XOR must reproduce the frame checksum.
               if ({5'd0, r_idx} == r_len - 16'd1) begin
                  if (w_rb != r_csum) begin
                     r_state <= S_ERROR;
                     r_err   <= ERR_VERIFY;
                     r_error <= 1'b1;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE, S_ERROR: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      o_rx_ready     = 1'b0;
      o_dbg_en       = 1'b0;
      o_dbg_write_en = 1'b0;
      o_dbg_addr     = 32'd0;
      o_dbg_wdata    = 32'd0;
      unique case (r_state)
         S_LEN_LO, S_LEN_HI, S_BYTE, S_CSUM: o_rx_ready = 1'b1;
         S_WRITE: begin
            o_dbg_en       = 1'b1;
            o_dbg_write_en = 1'b1;
            o_dbg_addr     = w_addr;
            o_dbg_wdata    = w_word;
         end
         S_VERIFY: begin
            o_dbg_en   = 1'b1;
            o_dbg_addr = w_addr;
         end
         default: o_rx_ready = 1'b0;
      endcase
   end

   assign o_busy         = r_busy;
   assign o_cpu_hold     = r_busy;
   assign o_done         = r_done;
   assign o_error        = r_error;
   assign o_err_code     = r_err;
   assign o_words_loaded = r_words;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader with a 1024-word memory model
// and a second write port used to corrupt the image during readback.
module tb_imem_program_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        dbg_en, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        cpu_hold, busy, done, error;
   logic [1:0]  err_code;
   logic [10:0] words_loaded;

   logic [31:0] mem [1024];
   logic [31:0] exp_img [1024];
   logic        mem_init = 1'b0;
   logic        corrupt_arm = 1'b0;
   logic        tb_we = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int wr_total = 0, vf_total = 0, done_total = 0;
   int err_total = 0, busy_total = 0, hold_bad = 0;
   int wr0, vf0, dn0, er0, bz0;

   always #5 clk = ~clk;

   imem_program_loader dut (
      .clk            (clk),
      .reset          (reset),
      .i_start        (start),
      .i_rx_data      (rx_data),
      .i_rx_valid     (rx_valid),
      .o_rx_ready     (rx_ready),
      .o_dbg_en       (dbg_en),
      .o_dbg_write_en (dbg_we),
      .o_dbg_addr     (dbg_addr),
      .o_dbg_wdata    (dbg_wdata),
      .i_dbg_rdata    (dbg_rdata),
      .o_cpu_hold     (cpu_hold),
      .o_busy         (busy),
      .o_done         (done),
      .o_error        (error),
      .o_err_code     (err_code),
      .o_words_loaded (words_loaded)
   );

   assign dbg_rdata = mem[dbg_addr[11:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0000_0013;
      end else begin
         if (dbg_en && dbg_we) mem[dbg_addr[11:2]] <= dbg_wdata;
         if (tb_we) mem[1] <= 32'h5566_7789;
      end
   end

   always @(negedge clk) begin
      if (dbg_en && dbg_we)  wr_total++;
      if (dbg_en && !dbg_we) vf_total++;
      if (done)              done_total++;
      if (error)             err_total++;
      if (busy)              busy_total++;
      if (cpu_hold !== busy) hold_bad++;
      tb_we <= corrupt_arm && dbg_en && !dbg_we && (dbg_addr == 32'd0);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic snap();
      wr0 = wr_total; vf0 = vf_total; dn0 = done_total;
      er0 = err_total; bz0 = busy_total;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      for (int g = 0; g < gap; g++) tick();
      rx_data  = b;
      rx_valid = 1'b1;
      w = 0;
      while (!rx_ready && w < 64) begin
         tick();
         w++;
      end
      if (!rx_ready) chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      else tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
   endtask

   task automatic wait_end();
      int c;
      c = 0;
      while (c < 40000 &&
             !(!busy && (done_total > dn0 || err_total > er0))) begin
         tick();
         c++;
      end
      if (c >= 40000) chk("end_timeout", 32'd0, 32'd1);
   endtask

   task automatic init_mem();
      mem_init = 1'b1;
      tick();
      mem_init = 1'b0;
   endtask

   initial begin
      logic [7:0]  cs;
      logic [31:0] wv;
      int          bad;

      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst_dbg_en", {31'd0, dbg_en}, 32'd0);
      chk("rst_dbg_we", {31'd0, dbg_we}, 32'd0);
      chk("rst_dbg_addr", dbg_addr, 32'd0);
      chk("rst_dbg_wdata", dbg_wdata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_flags", {29'd0, done, error, cpu_hold}, 32'd0);
      chk("rst_err_code", {30'd0, err_code}, 32'd0);
      chk("rst_words", {21'd0, words_loaded}, 32'd0);

      // N=2 back-to-back
      init_mem();
      snap();
      do_start();
      chk("t1_busy_rise", {31'd0, busy}, 32'd1);
      send_byte(8'h02, 0); send_byte(8'h00, 0);
      send_word(32'h0050_0093, 0);
      send_word(32'h00A0_0113, 0);
      send_byte(8'h71, 0);
      wait_end();
      chk("t1_done", done_total - dn0, 1);
      chk("t1_no_err", err_total - er0, 0);
      chk("t1_err_code", {30'd0, err_code}, 32'd0);
      chk("t1_words", {21'd0, words_loaded}, 32'd2);
      chk("t1_mem0", mem[0], 32'h0050_0093);
      chk("t1_mem1", mem[1], 32'h00A0_0113);
      chk("t1_mem2", mem[2], 32'h0000_0013);
      chk("t1_writes", wr_total - wr0, 2);
      chk("t1_verifies", vf_total - vf0, 2);
      chk("t1_cycles", busy_total - bz0 + 1, 17);

      // N=0 header
      snap();
      do_start();
      send_byte(8'h00, 0); send_byte(8'h00, 0);
      wait_end();
      chk("t2_error", err_total - er0, 1);
      chk("t2_err_code", {30'd0, err_code}, 32'd1);
      chk("t2_writes", wr_total - wr0, 0);

      // N=1025 header
      snap();
      do_start();
      send_byte(8'h01, 0); send_byte(8'h04, 0);
      wait_end();
      chk("t2b_error", err_total - er0, 1);
      chk("t2b_err_code", {30'd0, err_code}, 32'd1);
      chk("t2b_writes", wr_total - wr0, 0);

      // N=1, wrong checksum
      init_mem();
      snap();
      do_start();
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_word(32'hDEAD_BEEF, 1);
      send_byte(8'h00, 0);
      wait_end();
      chk("t3_error", err_total - er0, 1);
      chk("t3_err_code", {30'd0, err_code}, 32'd2);
      chk("t3_mem0", mem[0], 32'hDEAD_BEEF);
      chk("t3_verifies", vf_total - vf0, 0);
      chk("t3_words", {21'd0, words_loaded}, 32'd1);
      tick(); tick(); tick();
      chk("t3_code_held", {30'd0, err_code}, 32'd2);

      // N=2, word 1 corrupted during readback
      init_mem();
      snap();
      corrupt_arm = 1'b1;
      do_start();
      chk("t4_code_clr", {30'd0, err_code}, 32'd0);
      send_byte(8'h02, 0); send_byte(8'h00, 0);
      send_word(32'h1122_3344, 0);
      send_word(32'h5566_7788, 0);
      send_byte(8'h88, 0);
      wait_end();
      corrupt_arm = 1'b0;
      chk("t4_error", err_total - er0, 1);
      chk("t4_no_done", done_total - dn0, 0);
      chk("t4_err_code", {30'd0, err_code}, 32'd3);
      chk("t4_verifies", vf_total - vf0, 2);

      // N=1024 with random gaps
      init_mem();
      snap();
      cs = 8'h00;
      do_start();
      send_byte(8'h00, 1); send_byte(8'h04, 0);
      for (int i = 0; i < 1024; i++) begin
         wv = (32'(i) * 32'h9E37_79B9) ^ 32'(i);
         exp_img[i] = wv;
         cs = cs ^ wv[7:0] ^ wv[15:8] ^ wv[23:16] ^ wv[31:24];
         for (int k = 0; k < 4; k++)
            send_byte(wv[8*k +: 8], int'($urandom_range(0, 2)));
      end
      send_byte(cs, 2);
      wait_end();
      chk("t5_done", done_total - dn0, 1);
      chk("t5_err_code", {30'd0, err_code}, 32'd0);
      chk("t5_words", {21'd0, words_loaded}, 32'd1024);
      chk("t5_verifies", vf_total - vf0, 1024);
      chk("t5_min_cycles", {31'd0, (busy_total - bz0 + 1) >= 6149}, 32'd1);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== exp_img[i]) bad++;
      chk("t5_image_bad_words", bad, 0);

      // reset after 6 payload bytes of N=4
      init_mem();
      snap();
      do_start();
      send_byte(8'h04, 0); send_byte(8'h00, 0);
      send_word(32'h0403_0201, 0);
      send_byte(8'h05, 0); send_byte(8'h06, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("t6_dbg_en", {31'd0, dbg_en}, 32'd0);
      chk("t6_words", {21'd0, words_loaded}, 32'd0);
      chk("t6_mem0", mem[0], 32'h0403_0201);
      chk("t6_mem1", mem[1], 32'h0000_0013);
      snap();
      do_start();
      chk("t6_restart_busy", {31'd0, busy}, 32'd1);
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_word(32'hCAFE_F00D, 0);
      send_byte(8'hC9, 0);
      wait_end();
      chk("t6_done", done_total - dn0, 1);
      chk("t6_mem0_new", mem[0], 32'hCAFE_F00D);
      chk("cpu_hold_eq_busy", hold_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imem_program_loader.md
# imem_program_loader

Sequencer that loads a program image into the 1024-word instruction memory through its debug/load port. Accepts a framed byte stream (UART receiver or testbench), packs bytes into little-endian words, writes them at consecutive word addresses, checks a frame checksum, then reads the image back to verify it. Holds the CPU in stall while active and reports done/error status to the SoC top level.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; word-aligned.
- MAX_WORDS, 1024, largest accepted word count; equals instruction memory depth.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a load; sampled only in IDLE.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle; transfer = rx_valid & rx_ready.
- dbg_en  out  1  drives memory debug_en.
- dbg_write_en  out  1  drives memory debug_write_en.
- dbg_addr  out  32  drives memory debug_addr (byte address).
- dbg_wdata  out  32  drives memory debug_data_in.
- dbg_rdata  in  32  memory debug_data_out; combinational read of mem[dbg_addr[31:2]].
- cpu_hold  out  1  stall/reset request to the core.
- busy  out  1  loader not IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on failure.
- err_code  out  2  0 none, 1 bad length, 2 checksum mismatch, 3 verify mismatch; held until next accepted start.
- words_loaded  out  11  words written in the current/last load.

## Operation
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4·N payload bytes (each word LSB first), 1 checksum byte = XOR of all 4·N payload bytes.
- States: IDLE, LEN_LO, LEN_HI, BYTE, WRITE, CSUM, VERIFY, DONE, ERROR.
- IDLE: start=1 → LEN_LO; clears err_code, words_loaded, XOR accumulator, word index. start in any other state is ignored.
- LEN_LO/LEN_HI: rx_ready=1; on transfer latch byte. After LEN_HI: N==0 or N>MAX_WORDS → ERROR (code 1), else BYTE.
- BYTE: rx_ready=1; each transfer shifts byte into word at lane byte_cnt, XORs into accumulator; 4th transfer → WRITE.
- WRITE: rx_ready=0; dbg_en=dbg_write_en=1, dbg_addr=BASE_ADDR+4·idx, dbg_wdata=packed word; idx+1, words_loaded+1; → BYTE if idx+1<N, else CSUM.
- CSUM: rx_ready=1; on transfer compare byte with accumulator: mismatch → ERROR (code 2), match → VERIFY with idx=0 and a second (readback) accumulator cleared.
- VERIFY: dbg_en=1, dbg_write_en=0, dbg_addr=BASE_ADDR+4·idx; XOR the four bytes of dbg_rdata into readback accumulator; one word per cycle. On idx==N-1: final readback XOR (including this word) ≠ received checksum → ERROR (code 3), else DONE.
- DONE: done=1 one cycle → IDLE. ERROR: error=1 one cycle → IDLE.
- dbg_en=0 outside WRITE/VERIFY; dbg_addr/dbg_wdata don't-care then, driven 0.
- busy=cpu_hold=1 in every state except IDLE.
- Address arithmetic in 32 bits; idx 11 bits; BASE_ADDR+4·(MAX_WORDS-1) must not exceed memory range (checked at elaboration).

## Timing
- Reset values: rx_ready 0, dbg_en 0, dbg_write_en 0, dbg_addr 0, dbg_wdata 0, cpu_hold 0, busy 0, done 0, error 0, err_code 0, words_loaded 0; state IDLE.
- Reset mid-operation: next cycle IDLE with reset values; words already written remain in memory.
- start→LEN_LO: 1 cycle; busy/cpu_hold rise the cycle after start sampled.
- Each word costs ≥5 cycles (4 byte transfers + 1 WRITE); rx_valid gaps stall without side effects.
- Checksum byte accepted → first VERIFY cycle next cycle; VERIFY lasts exactly N cycles; DONE follows; busy falls the cycle after DONE.
- Minimum total for N words with back-to-back bytes: 1+2+5N+1+N+1 cycles after start.
- Outputs registered except rx_ready, dbg_* which decode from state/registers only (no rx_valid combinational path).

## Structure
- constants.v: state encodings, ERR_NONE/ERR_LEN/ERR_CSUM/ERR_VERIFY, IMEM_WORDS=1024, NOP=32'h0000_0013.
- Sub-module byte_word_packer: byte lane counter, little-endian shift register, XOR accumulator, word_ready flag; loader FSM instantiates it once.

## Test plan
- N=2, words 32'h00500093, 32'h00A00113, correct checksum 0x3A ^ … (computed) → two WRITEs at 0x0 and 0x4, mem matches, done pulse, err_code 0, words_loaded 2.
- N=0 header (0x00,0x00) → error pulse, err_code 1, no dbg_write_en ever asserted.
- N=1 word 32'hDEADBEEF, checksum 0x00 (correct 0x22) → word written, error, err_code 2, no VERIFY cycles.
- Force memory word 0 corrupted via second debug writer during VERIFY, N=1 → err_code 3.
- Random rx_valid gaps, N=1024, BASE_ADDR 0 → all 1024 words correct, done, cycle count ≥ 6·1024+5.
- reset asserted after 6 payload bytes of N=4 → IDLE next cycle, word 0 present, word 1 unchanged NOP, start re-accepted.
